sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single-port 1024x8 SRAM between two requesters: the CPU core (high priority) and the serial/SPI loader-dump path (low priority).
- Owns the SRAM control pins CEN, WEN, A and D, all active-low where applicable, and returns read data to the owning port.
- Enforces an aging limit so a continuously active CPU cannot starve the loader.
- Sits between the CPU/control block and the SRAM macro inside the chip top.

Parameters:
- ADDR_WIDTH, 10, SRAM address width.
- DATA_WIDTH, 8, SRAM data width.
- MAX_WAIT, 4, consecutive denied cycles after which the loader wins over the CPU (range 1..15).

Ports:
- CLK  in  1  system clock; rising-edge active.
- RST_N  in  1  asynchronous active-low reset.
- CPU_REQ  in  1  CPU access request, held until granted.
- CPU_WE  in  1  1=write, 0=read.
- CPU_ADDR  in  ADDR_WIDTH  CPU address.
- CPU_WDATA  in  DATA_WIDTH  CPU write data.
- CPU_GNT  out  1  CPU access accepted this cycle.
- CPU_RVALID  out  1  CPU read data valid.
- CPU_RDATA  out  DATA_WIDTH  CPU read data.
- SPI_REQ, SPI_WE, SPI_ADDR, SPI_WDATA, SPI_GNT, SPI_RVALID, SPI_RDATA: identical meaning for the loader port.
- CEN  out  1  SRAM chip enable, active-low.
- WEN  out  1  SRAM write enable, active-low.
- A  out  ADDR_WIDTH  SRAM address.
- D  out  DATA_WIDTH  SRAM write data.
- Q  in  DATA_WIDTH  SRAM read data, valid in the cycle after the access edge.

Behaviour:
- One clock, CLK. Reset is RST_N: asynchronous assert, active-low, synchronous deassert handled upstream.
- Reset values:
  - CEN=1, WEN=1, A=0, D=0.
  - GNT=0 and RVALID=0 on both ports.
  - RDATA=0 on both ports.
  - age=0, rd_owner=NONE.
- Arbitration is combinational within the cycle:
  - sel_spi = SPI_REQ & (~CPU_REQ | age==MAX_WAIT).
  - sel_cpu = CPU_REQ & ~sel_spi.
  - At most one GNT is high per cycle.
- SRAM drive:
  - When a port is selected: CEN=0, WEN=~WE, A/D from that port.
  - When neither is selected: CEN=1, WEN=1, A/D hold their last driven value. A/D are registered shadow values updated only on grant, so the pins do not toggle while idle.
- Age counter:
  - Increments each cycle that SPI_REQ=1 and SPI is not granted.
  - Saturates at MAX_WAIT.
  - Clears when SPI is granted or SPI_REQ=0.
- Read return, with a latency of exactly 1 cycle:
  - On a granted read, rd_owner <= that port; otherwise rd_owner <= NONE.
  - In the next cycle the owner's RVALID=1 and its RDATA=Q.
  - The non-owner's RDATA holds its last value.
- Writes produce no RVALID.
- Back-to-back accesses are legal every cycle. There are no bubbles and no turnaround cycle between read and write.
- A request is accepted only in its GNT cycle. The requester must hold REQ/WE/ADDR/WDATA stable until GNT.
- Reset mid-operation: a pending RVALID is dropped, age is cleared, and CEN/WEN go to 1 immediately (asynchronous).
- X on REQ is treated as a protocol violation (simulation assertion only).

Decomposition:
- Shared package (sram_arb_pkg):
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - Owner encoding OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_SPI=2'd2.
  - MAX_WAIT default.
- One sub-module, sram_arb_age_cnt: saturating 4-bit counter with inc/clr inputs and an at_limit output.
- Everything else stays in the top arbiter.

Test Plan:
- Reset: hold RST_N=0 with both REQ=1 -> CEN=1, WEN=1, both GNT=0, both RVALID=0. Release RST_N -> CPU_GNT=1 in the first cycle.
- CPU write 0x3A5<=0xC3, then CPU read 0x3A5 -> read GNT one cycle after the write. CPU_RVALID=1 and CPU_RDATA=0xC3 the next cycle. SPI_RVALID stays 0.
- SPI alone reads 0x000..0x003 back-to-back -> SPI_GNT high for 4 consecutive cycles. SPI_RVALID high for 4 cycles, delayed by 1.
- Starvation: CPU_REQ and SPI_REQ held high, MAX_WAIT=4 -> CPU granted 4 cycles, SPI granted on the 5th, then CPU 4 more. The pattern repeats with exactly one SPI grant per 5 cycles.
- Interleaved read ownership: CPU read cycle N, SPI read cycle N+1 -> CPU_RVALID at N+1 and SPI_RVALID at N+2 each carry the correct Q. There is never a simultaneous RVALID.
- Reset asserted in the cycle after a granted read -> that RVALID never appears and age=0 after reset.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared widths, limits and read-owner encoding for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 10;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned MAX_WAIT_DEF   = 4;
  localparam int unsigned AGE_WIDTH      = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_SPI  = 2'd2
  } owner_e;

endpackage

// File: rtl/sram_arb_age_cnt.sv
// Saturating wait counter: counts loader cycles spent denied, flags when the limit is reached.
module sram_arb_age_cnt
  import sram_arb_pkg::*;
#(
  parameter int unsigned MaxWait = MAX_WAIT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [AGE_WIDTH-1:0] Limit = AGE_WIDTH'(MaxWait);

  logic [AGE_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + AGE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == Limit);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for the single-port SRAM: CPU has priority, loader wins after MAX_WAIT denials.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CPU_REQ,
  input  logic                  CPU_WE,
  input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
  input  logic [DATA_WIDTH-1:0] CPU_WDATA,
  output logic                  CPU_GNT,
  output logic                  CPU_RVALID,
  output logic [DATA_WIDTH-1:0] CPU_RDATA,
  input  logic                  SPI_REQ,
  input  logic                  SPI_WE,
  input  logic [ADDR_WIDTH-1:0] SPI_ADDR,
  input  logic [DATA_WIDTH-1:0] SPI_WDATA,
  output logic                  SPI_GNT,
  output logic                  SPI_RVALID,
  output logic [DATA_WIDTH-1:0] SPI_RDATA,
  output logic                  CEN,
  output logic                  WEN,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  logic                  at_limit;
  logic                  sel_spi, sel_cpu, sel_any;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, spi_rdata_q;
  owner_e                rd_owner_q, rd_owner_d;

  // Grants are gated by RST_N so the pins go idle the instant reset asserts.
  assign sel_spi = RST_N & SPI_REQ & (~CPU_REQ | at_limit);
  assign sel_cpu = RST_N & CPU_REQ & ~sel_spi;
  assign sel_any = sel_spi | sel_cpu;

  assign CPU_GNT = sel_cpu;
  assign SPI_GNT = sel_spi;

  sram_arb_age_cnt #(
    .MaxWait (MAX_WAIT)
  ) u_age_cnt (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .inc_i      (SPI_REQ & ~sel_spi),
    .clr_i      (~SPI_REQ | sel_spi),
    .at_limit_o (at_limit)
  );

  // Idle cycles replay the shadowed A/D so the address/data pins do not toggle.
  always_comb begin
    CEN        = 1'b1;
    WEN        = 1'b1;
    A          = a_q;
    D          = d_q;
    rd_owner_d = OWN_NONE;
    if (sel_cpu) begin
      CEN = 1'b0;
      WEN = ~CPU_WE;
      A   = CPU_ADDR;
      D   = CPU_WDATA;
      if (!CPU_WE) rd_owner_d = OWN_CPU;
    end else if (sel_spi) begin
      CEN = 1'b0;
      WEN = ~SPI_WE;
      A   = SPI_ADDR;
      D   = SPI_WDATA;
      if (!SPI_WE) rd_owner_d = OWN_SPI;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q        <= '0;
      d_q        <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
      if (sel_any) begin
        a_q <= A;
        d_q <= D;
      end
    end
  end

  assign CPU_RVALID = (rd_owner_q == OWN_CPU);
  assign SPI_RVALID = (rd_owner_q == OWN_SPI);

  // Q is only valid in the cycle after the access, so the owner sees it live and
  // the hold registers capture it for later cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cpu_rdata_q <= '0;
      spi_rdata_q <= '0;
    end else begin
      if (CPU_RVALID) cpu_rdata_q <= Q;
      if (SPI_RVALID) spi_rdata_q <= Q;
    end
  end

  assign CPU_RDATA = CPU_RVALID ? Q : cpu_rdata_q;
  assign SPI_RDATA = SPI_RVALID ? Q : spi_rdata_q;

  a_req_known: assert property (@(posedge CLK) disable iff (!RST_N)
    !$isunknown({CPU_REQ, SPI_REQ}));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1024x8 SRAM behind it.
module tb_sram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       cpu_req, cpu_we, spi_req, spi_we;
  logic [9:0] cpu_addr, spi_addr, a;
  logic [7:0] cpu_wdata, spi_wdata, cpu_rdata, spi_rdata, d, q;
  logic       cpu_gnt, cpu_rvalid, spi_gnt, spi_rvalid, cen, wen;
  logic [7:0] mem [1024];

  int n_checks = 0;
  int n_errors = 0;

  sram_port_arbiter #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (8),
    .MAX_WAIT   (4)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .CPU_REQ    (cpu_req),
    .CPU_WE     (cpu_we),
    .CPU_ADDR   (cpu_addr),
    .CPU_WDATA  (cpu_wdata),
    .CPU_GNT    (cpu_gnt),
    .CPU_RVALID (cpu_rvalid),
    .CPU_RDATA  (cpu_rdata),
    .SPI_REQ    (spi_req),
    .SPI_WE     (spi_we),
    .SPI_ADDR   (spi_addr),
    .SPI_WDATA  (spi_wdata),
    .SPI_GNT    (spi_gnt),
    .SPI_RVALID (spi_rvalid),
    .SPI_RDATA  (spi_rdata),
    .CEN        (cen),
    .WEN        (wen),
    .A          (a),
    .D          (d),
    .Q          (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem[a] <= d;
      else      q <= mem[a];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] pre [4];

  initial begin
    pre[0] = 8'h5A; pre[1] = 8'hA5; pre[2] = 8'h0F; pre[3] = 8'hF0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem[i] = pre[i];
    q = 8'h00;

    // Reset with both requesting, CPU write pending.
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3A5; cpu_wdata = 8'hC3;
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 10'h000; spi_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cen", cen, 1);
    check("rst_wen", wen, 1);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_spi_gnt", spi_gnt, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_spi_rvalid", spi_rvalid, 0);
    check("rst_a", a, 0);
    check("rst_d", d, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_spi_rdata", spi_rdata, 0);

    // First cycle out of reset: CPU write 0x3A5 <= 0xC3.
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("wr_cpu_gnt", cpu_gnt, 1);
    check("wr_spi_gnt", spi_gnt, 0);
    check("wr_cen", cen, 0);
    check("wr_wen", wen, 0);
    check("wr_a", a, 10'h3A5);
    check("wr_d", d, 8'hC3);

    // CPU read of the same address.
    next_cycle();
    spi_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_wen", wen, 1);
    check("rd_cpu_rvalid_early", cpu_rvalid, 0);

    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 8'hC3);
    check("rd_spi_rvalid", spi_rvalid, 0);
    check("idle_cen", cen, 1);
    check("idle_a_hold", a, 10'h3A5);
    check("idle_d_hold", d, 8'hC3);

    // SPI alone: back-to-back reads of 0..3.
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      spi_req  = (k < 4);
      spi_addr = 10'(k);
      @(negedge clk);
      check($sformatf("spi_gnt_%0d", k), spi_gnt, (k < 4) ? 1 : 0);
      check($sformatf("spi_rvalid_%0d", k), spi_rvalid, (k >= 1 && k <= 4) ? 1 : 0);
      if (k >= 1 && k <= 4) check($sformatf("spi_rdata_%0d", k), spi_rdata, pre[k-1]);
      check($sformatf("spi_cpu_rdata_hold_%0d", k), cpu_rdata, 8'hC3);
    end

    // Starvation: both held, one SPI grant every fifth cycle.
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 10'h010; spi_req = 1'b1; spi_addr = 10'h001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("age_cpu_gnt_%0d", i), cpu_gnt, (i % 5 != 4) ? 1 : 0);
      check($sformatf("age_spi_gnt_%0d", i), spi_gnt, (i % 5 == 4) ? 1 : 0);
      check($sformatf("age_one_rvalid_%0d", i), cpu_rvalid & spi_rvalid, 0);
      next_cycle();
    end
    cpu_req = 1'b0; spi_req = 1'b0;
    next_cycle();

    // Interleaved read ownership.
    cpu_req = 1'b1; cpu_addr = 10'h002;
    @(negedge clk);
    check("il_cpu_gnt", cpu_gnt, 1);
    next_cycle();
    cpu_req = 1'b0; spi_req = 1'b1; spi_addr = 10'h003;
    @(negedge clk);
    check("il_spi_gnt", spi_gnt, 1);
    check("il_cpu_rvalid", cpu_rvalid, 1);
    check("il_cpu_rdata", cpu_rdata, 8'h0F);
    check("il_spi_rvalid_n1", spi_rvalid, 0);
    next_cycle();
    spi_req = 1'b0;
    @(negedge clk);
    check("il_spi_rvalid", spi_rvalid, 1);
    check("il_spi_rdata", spi_rdata, 8'hF0);
    check("il_cpu_rvalid_n2", cpu_rvalid, 0);
    check("il_cpu_rdata_hold", cpu_rdata, 8'h0F);

    // Build some age, then reset right after a granted CPU read.
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 10'h000; spi_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("pre_rst_cpu_gnt_%0d", i), cpu_gnt, 1);
      if (i < 2) next_cycle();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_cen", cen, 1);
    check("midrst_wen", wen, 1);
    check("midrst_cpu_gnt", cpu_gnt, 0);
    next_cycle();
    check("midrst_cpu_rvalid", cpu_rvalid, 0);
    check("midrst_cpu_rdata", cpu_rdata, 0);
    next_cycle();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("post_rst_cpu_gnt_%0d", j), cpu_gnt, (j < 4) ? 1 : 0);
      check($sformatf("post_rst_spi_gnt_%0d", j), spi_gnt, (j == 4) ? 1 : 0);
      if (j == 0) check("post_rst_cpu_rvalid", cpu_rvalid, 0);
      next_cycle();
    end
    cpu_req = 1'b0; spi_req = 1'b0;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
